// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_pkg
// Purpose  : Shared constants and state type for the Ethernet FCS checker.
// Revision : 1.0 - initial release
// ============================================================================
package eth_pkg;

  // Reflected CRC-32 generator, preset, and the good-frame residue left in
  // the register after the FCS bytes themselves have been run through it.
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  // Legal frame length window in bytes, FCS included.
  localparam int ETH_MIN_FRAME = 64;
  localparam int ETH_MAX_FRAME = 1518;

  // Largest value the 11-bit length counter can hold before it saturates.
  localparam logic [10:0] LEN_SAT = 11'd2047;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } fcs_state_t;

endpackage
`default_nettype wire

// File: rtl/crc32_d8.sv
`default_nettype none
// ============================================================================
// Module   : crc32_d8
// Purpose  : One-byte step of the reflected CRC-32, data consumed LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  logic [31:0] crc_work;

  // Unrolled bit-serial LFSR: eight shifts, one per data bit, LSB first.
  always_comb begin
    crc_work = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_work[0] ^ data[i]) begin
        crc_work = (crc_work >> 1) ^ CRC32_POLY_REFL;
      end else begin
        crc_work = crc_work >> 1;
      end
    end
    crc_next = crc_work;
  end

endmodule
`default_nettype wire

// File: rtl/eth_fcs_checker.sv
`default_nettype none
// ============================================================================
// Module   : eth_fcs_checker
// Purpose  : Checks the Ethernet FCS of a byte stream, strips the last four
//            bytes through a 4-deep delay line and reports per-frame status.
// Revision : 1.0 - initial release
// ============================================================================
module eth_fcs_checker
  import eth_pkg::*;
#(
  parameter int MIN_LEN = ETH_MIN_FRAME,
  parameter int MAX_LEN = ETH_MAX_FRAME
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_sof,
  input  logic        in_eof,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        err_fcs,
  output logic        err_runt,
  output logic        err_long,
  output logic        err_abort,
  output logic [10:0] frame_len
);

  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);

  fcs_state_t  state;
  logic [31:0] crc;
  logic [10:0] len;
  logic [31:0] dly_line;     // newest byte in [7:0], oldest in [31:24]
  logic [1:0]  fill_cnt;
  logic        sof_pending;  // next emitted byte is the first payload byte

  logic        start;
  logic [31:0] crc_seed;
  logic [31:0] crc_next;
  logic [10:0] len_next;
  logic        fcs_bad_next;
  logic        runt_next;
  logic        long_next;

  // A start-of-frame beat restarts the CRC and the length from scratch.
  assign start    = in_valid & in_sof;
  assign crc_seed = start ? CRC32_INIT : crc;
  assign len_next = start ? 11'd1 : ((len == LEN_SAT) ? len : len + 11'd1);

  crc32_d8 u_crc (
    .crc_in   (crc_seed),
    .data     (in_data),
    .crc_next (crc_next)
  );

  assign fcs_bad_next = (crc_next != CRC32_RESIDUE);
  assign runt_next    = (len_next < MIN_L);
  assign long_next    = (len_next > MAX_L);

  // Frame tracking FSM, delay line and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      crc         <= CRC32_INIT;
      len         <= 11'd0;
      dly_line    <= 32'd0;
      fill_cnt    <= 2'd0;
      sof_pending <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= 8'd0;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      err_fcs     <= 1'b0;
      err_runt    <= 1'b0;
      err_long    <= 1'b0;
      err_abort   <= 1'b0;
      frame_len   <= 11'd0;
    end else begin
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_fcs    <= 1'b0;
      err_runt   <= 1'b0;
      err_long   <= 1'b0;
      err_abort  <= 1'b0;
      if (in_valid) begin
        if (in_sof) begin
          // A new SOF while a frame is open closes the old one as aborted.
          if (state != ST_IDLE) begin
            frame_done <= 1'b1;
            frame_len  <= len;
            err_fcs    <= (crc != CRC32_RESIDUE);
            err_runt   <= (len < MIN_L);
            err_long   <= (len > MAX_L);
            err_abort  <= 1'b1;
          end
          crc         <= crc_next;
          len         <= 11'd1;
          dly_line    <= {dly_line[23:0], in_data};
          fill_cnt    <= 2'd1;
          sof_pending <= 1'b1;
          if (in_eof) begin
            // Single-byte frame; when it also aborts a frame, only the
            // abort can be reported and the one-byte frame is dropped.
            state <= ST_IDLE;
            if (state == ST_IDLE) begin
              frame_done <= 1'b1;
              frame_len  <= len_next;
              err_fcs    <= fcs_bad_next;
              err_runt   <= runt_next;
              err_long   <= long_next;
              frame_ok   <= ~(fcs_bad_next | runt_next | long_next);
            end
          end else begin
            state <= ST_FILL;
          end
        end else if (state != ST_IDLE) begin
          crc      <= crc_next;
          len      <= len_next;
          dly_line <= {dly_line[23:0], in_data};
          if (state == ST_STREAM) begin
            out_valid   <= 1'b1;
            out_data    <= dly_line[31:24];
            out_sof     <= sof_pending;
            out_eof     <= in_eof;
            sof_pending <= 1'b0;
          end else begin
            fill_cnt <= fill_cnt + 2'd1;
            if (fill_cnt == 2'd3) begin
              state <= ST_STREAM;
            end
          end
          // The four bytes still in the delay line are the FCS; drop them.
          if (in_eof) begin
            state      <= ST_IDLE;
            frame_done <= 1'b1;
            frame_len  <= len_next;
            err_fcs    <= fcs_bad_next;
            err_runt   <= runt_next;
            err_long   <= long_next;
            frame_ok   <= ~(fcs_bad_next | runt_next | long_next);
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eth_fcs_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_fcs_checker
// Purpose  : Randomised frame-level checking of eth_fcs_checker against a
//            queue-based reference model, plus hand-computed anchors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_fcs_checker;

  localparam int TB_MIN = 5;
  localparam int TB_MAX = 1518;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_sof = 1'b0;
  logic        in_eof = 1'b0;
  logic        out_valid, out_sof, out_eof, frame_done;
  logic        frame_ok, err_fcs, err_runt, err_long, err_abort;
  logic [7:0]  out_data;
  logic [10:0] frame_len;

  always #5 clock = ~clock;

  eth_fcs_checker #(.MIN_LEN(TB_MIN), .MAX_LEN(TB_MAX)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof), .in_eof(in_eof),
    .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
    .frame_done(frame_done), .frame_ok(frame_ok), .err_fcs(err_fcs),
    .err_runt(err_runt), .err_long(err_long), .err_abort(err_abort),
    .frame_len(frame_len)
  );

  typedef logic [7:0] bq_t[$];
  typedef struct { int cyc; logic [7:0] d; logic sof; logic eof; } pay_t;
  typedef struct { int cyc; logic [10:0] len; logic ok, fcs, runt, lng, abrt; } st_t;

  pay_t pay_q[$];
  st_t  st_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bq_t  cur;          // bytes of the frame currently open in the model
  bit   active = 0;
  bq_t  fr;           // frame being built / sent

  logic [10:0] last_len;
  logic        last_ok, last_fcs, last_runt, last_lng;
  int          pay_cnt = 0;
  int          done_cnt = 0;
  int          abort_cnt = 0;
  bq_t         got_pay;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Reference CRC register (reflected, preset all ones, no final inversion).
  function automatic logic [31:0] crc_of(input bq_t q);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) begin
        c = (c[0] ^ q[i][b]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return c;
  endfunction

  // Status the frame held in 'cur' must produce.
  task automatic model_status(input bit abort, input int exp_cyc);
    st_t s;
    bq_t p;
    logic [31:0] fcs_rx;
    int n = cur.size();
    s.cyc  = exp_cyc;
    s.len  = (n > 2047) ? 11'd2047 : 11'(n);
    s.runt = (n < TB_MIN);
    s.lng  = (n > TB_MAX);
    s.abrt = abort;
    if (n >= 4) begin
      for (int i = 0; i < n - 4; i++) p.push_back(cur[i]);
      fcs_rx = {cur[n-1], cur[n-2], cur[n-3], cur[n-4]};
      s.fcs  = ((~crc_of(p)) != fcs_rx);
    end else begin
      s.fcs  = (crc_of(cur) != 32'hDEBB20E3);
    end
    s.ok = !(s.fcs | s.runt | s.lng | s.abrt);
    st_q.push_back(s);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Drive one accepted beat and record what the model says it must cause.
  task automatic drive_beat(input logic [7:0] d, input bit sof, input bit eof);
    int   ec = cyc + 1;
    int   n;
    pay_t pe;
    in_valid = 1'b1; in_data = d; in_sof = sof; in_eof = eof;
    if (sof) begin
      if (active) model_status(1'b1, ec);
      cur.delete();
      active = 1;
    end
    if (active) begin
      cur.push_back(d);
      n = cur.size();
      if (n >= 5) begin
        pe.cyc = ec; pe.d = cur[n-5]; pe.sof = (n == 5); pe.eof = eof;
        pay_q.push_back(pe);
      end
      if (eof) begin
        model_status(1'b0, ec);
        active = 0;
      end
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
  endtask

  task automatic make_frame(input int n, input bit corrupt);
    logic [31:0] c;
    int idx;
    fr.delete();
    if (n < 4) begin
      for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
    end else begin
      for (int i = 0; i < n - 4; i++) fr.push_back(8'($urandom));
      c = ~crc_of(fr);
      fr.push_back(c[7:0]); fr.push_back(c[15:8]);
      fr.push_back(c[23:16]); fr.push_back(c[31:24]);
      if (corrupt) begin
        idx = $urandom_range(0, n - 1);
        fr[idx] = fr[idx] ^ 8'(1 << $urandom_range(0, 7));
      end
    end
  endtask

  task automatic send(input int upto, input bit gaps);
    for (int i = 0; i < upto; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      drive_beat(fr[i], i == 0, i == fr.size() - 1);
    end
  endtask

  // Single compare process: every output beat and status pulse vs the model.
  always @(negedge clock) begin
    pay_t e;
    st_t  s;
    if (out_valid === 1'b1) begin
      pay_cnt++;
      got_pay.push_back(out_data);
      if (pay_q.size() == 0) begin
        fail("unexpected_out_valid");
      end else begin
        e = pay_q.pop_front();
        chk("out_cycle", cyc, e.cyc);
        chk("out_data", out_data, e.d);
        chk("out_sof", out_sof, e.sof);
        chk("out_eof", out_eof, e.eof);
      end
    end
    while (pay_q.size() > 0 && pay_q[0].cyc < cyc) begin
      fail("missing_out_valid");
      void'(pay_q.pop_front());
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      last_len = frame_len; last_ok = frame_ok; last_fcs = err_fcs;
      last_runt = err_runt; last_lng = err_long;
      if (err_abort === 1'b1) abort_cnt++;
      if (st_q.size() == 0) begin
        fail("unexpected_frame_done");
      end else begin
        s = st_q.pop_front();
        chk("done_cycle", cyc, s.cyc);
        chk("frame_len", frame_len, s.len);
        chk("err_abort", err_abort, s.abrt);
        chk("frame_ok", frame_ok, s.ok);
        if (!s.abrt) begin
          chk("err_fcs", err_fcs, s.fcs);
          chk("err_runt", err_runt, s.runt);
          chk("err_long", err_long, s.lng);
        end
      end
    end
    while (st_q.size() > 0 && st_q[0].cyc < cyc) begin
      fail("missing_frame_done");
      void'(st_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, snap;
    reset = 1'b1;
    idle(3);
    chk("reset_flags", {out_valid, out_sof, out_eof, frame_done, frame_ok,
                        err_fcs, err_runt, err_long, err_abort}, 9'd0);
    chk("reset_data_len", {out_data, frame_len}, 19'd0);
    reset = 1'b0;
    idle(2);

    // Known answer for the model's CRC: "123456789" -> CBF43926.
    fr = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("model_crc_check", ~crc_of(fr), 32'hCBF43926);

    // "123456789" with its FCS, back to back.
    fr = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
          8'h26, 8'h39, 8'hF4, 8'hCB};
    pay_cnt = 0; got_pay.delete();
    send(fr.size(), 0); idle(3);
    chk("A_len", last_len, 11'd13);
    chk("A_ok", last_ok, 1'b1);
    chk("A_paycnt", pay_cnt, 9);
    for (int i = 0; i < 9; i++) begin
      if (got_pay.size() > i) chk("A_payload", got_pay[i], 8'(8'h31 + i));
      else fail("A_payload_short");
    end

    // Same frame, last FCS byte CB -> CA.
    fr[12] = 8'hCA;
    pay_cnt = 0;
    send(fr.size(), 0); idle(3);
    chk("B_fcs", last_fcs, 1'b1);
    chk("B_ok", last_ok, 1'b0);
    chk("B_paycnt", pay_cnt, 9);

    // 64-byte valid frame with random gaps.
    make_frame(64, 0); pay_cnt = 0;
    send(fr.size(), 1); idle(3);
    chk("C_len", last_len, 11'd64);
    chk("C_ok", last_ok, 1'b1);
    chk("C_paycnt", pay_cnt, 60);

    // Short frames: 3, 4 bytes runt with no payload; single-beat frame.
    make_frame(3, 0); pay_cnt = 0;
    send(fr.size(), 0); idle(3);
    chk("runt3_runt", last_runt, 1'b1);
    chk("runt3_paycnt", pay_cnt, 0);
    make_frame(4, 0); pay_cnt = 0;
    send(fr.size(), 1); idle(3);
    chk("runt4_runt", last_runt, 1'b1);
    chk("runt4_paycnt", pay_cnt, 0);
    drive_beat(8'h5A, 1, 1); idle(3);
    chk("one_byte_len", last_len, 11'd1);
    chk("one_byte_runt", last_runt, 1'b1);
    make_frame(5, 0); pay_cnt = 0;
    send(fr.size(), 0); idle(3);
    chk("min5_ok", last_ok, 1'b1);
    chk("min5_paycnt", pay_cnt, 1);

    // Upper length boundary and saturation.
    make_frame(1518, 0); send(fr.size(), 0); idle(3);
    chk("max_ok", last_ok, 1'b1);
    make_frame(1519, 0); send(fr.size(), 0); idle(3);
    chk("long_err", last_lng, 1'b1);
    make_frame(2100, 0); send(fr.size(), 0); idle(3);
    chk("sat_len", last_len, 11'd2047);

    // SOF arriving at byte 20 aborts the first frame.
    snap = abort_cnt;
    make_frame(40, 0); send(19, 1);
    make_frame(40, 0); send(fr.size(), 1); idle(3);
    chk("abort_seen", abort_cnt - snap, 1);
    chk("after_abort_ok", last_ok, 1'b1);

    // Reset on byte 10 discards the frame.
    make_frame(30, 0); send(9, 0);
    in_valid = 1'b1; in_data = fr[9]; reset = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    cur.delete(); active = 0;
    snap = done_cnt;
    idle(2);
    chk("midrst_outputs", {out_valid, frame_done}, 2'b00);
    reset = 1'b0;
    idle(6);
    chk("midrst_no_done", done_cnt - snap, 0);
    make_frame(50, 0); send(fr.size(), 1); idle(3);
    chk("after_rst_ok", last_ok, 1'b1);

    // Random frames: random lengths, corruption, gaps and aborts.
    for (int f = 0; f < 30; f++) begin
      n = $urandom_range(2, 120);
      make_frame(n, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(1, n - 1);
        send(k, 1);
      end else begin
        send(fr.size(), 1);
      end
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 4));
    end
    make_frame(20, 0); send(fr.size(), 1);
    idle(10);
    chk("pay_queue_drained", pay_q.size(), 0);
    chk("status_queue_drained", st_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
